// File: rtl/assoc_cache.sv
// N-way set-associative write-back/write-allocate data cache, FIFO/LRU/random replacement.
// Define ASSOC_CACHE_STATS_EN to build the saturating hit_cnt/miss_cnt counters.
module assoc_cache #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 3,
    parameter int TAG_ADDR_LEN  = 6,
    parameter int WAY_CNT       = 4,
    parameter int REPL          = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [31:0]                            addr,
    input  logic                                   rd_req,
    input  logic                                   wr_req,
    input  logic [31:0]                            wr_data,
    input  logic [3:0]                             wr_be,
    output logic [31:0]                            rd_data,
    output logic                                   miss,
    output logic                                   mem_req,
    output logic                                   mem_we,
    output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0]   mem_addr,
    output logic [32*(1<<LINE_ADDR_LEN)-1:0]       mem_wr_line,
    input  logic [32*(1<<LINE_ADDR_LEN)-1:0]       mem_rd_line,
    input  logic                                   mem_gnt,
    output logic [31:0]                            hit_cnt,
    output logic [31:0]                            miss_cnt
);
    localparam int SET_CNT   = 1 << SET_ADDR_LEN;
    localparam int LINE_BITS = 32 * (1 << LINE_ADDR_LEN);
    localparam int WAY_W     = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;
    localparam int MA_W      = TAG_ADDR_LEN + SET_ADDR_LEN;

    typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;
    typedef logic [WAY_W-1:0] way_t;
    typedef way_t [WAY_CNT-1:0] order_t;

    state_t                    state;
    logic [LINE_BITS-1:0]      data_arr  [SET_CNT][WAY_CNT];
    logic [TAG_ADDR_LEN-1:0]   tag_arr   [SET_CNT][WAY_CNT];
    logic [WAY_CNT-1:0]        valid_arr [SET_CNT];
    logic [WAY_CNT-1:0]        dirty_arr [SET_CNT];
    order_t                    order_arr [SET_CNT];
    logic [7:0]                lfsr;
    logic [LINE_BITS-1:0]      fill_line;
    logic [MA_W-1:0]           fill_addr;
    way_t                      victim_q;

    logic [LINE_ADDR_LEN-1:0]  word_idx;
    logic [SET_ADDR_LEN-1:0]   set_idx;
    logic [TAG_ADDR_LEN-1:0]   tag;
    logic [SET_ADDR_LEN-1:0]   fill_set;
    logic [TAG_ADDR_LEN-1:0]   fill_tag;
    logic [31:0]               addr_unused;
    logic                      req, hit, has_inv;
    way_t                      hit_way, inv_way, victim;

    assign addr_unused = addr;
    assign word_idx = addr[LINE_ADDR_LEN+1:2];
    assign set_idx  = addr[SET_ADDR_LEN+LINE_ADDR_LEN+1:LINE_ADDR_LEN+2];
    assign tag      = addr[MA_W+LINE_ADDR_LEN+1:SET_ADDR_LEN+LINE_ADDR_LEN+2];
    assign fill_set = fill_addr[SET_ADDR_LEN-1:0];
    assign fill_tag = fill_addr[MA_W-1:SET_ADDR_LEN];

    assign req     = rd_req | wr_req;
    assign miss    = req & ~(hit & (state == IDLE));
    assign mem_req = (state == SWAP_OUT) || (state == SWAP_IN);
    assign mem_we  = (state == SWAP_OUT);

    // Order list per set: entry 0 is the next victim, the last entry the most recent.
    function automatic order_t promote(input order_t o, input way_t w);
        order_t      r;
        int unsigned pos;
        pos = 0;
        for (int unsigned i = 0; i < WAY_CNT; i++)
            if (o[i] == w) pos = i;
        r = o;
        for (int unsigned i = 0; i + 1 < WAY_CNT; i++)
            r[i] = (i < pos) ? o[i] : o[i+1];
        r[WAY_CNT-1] = w;
        return r;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int unsigned w = 0; w < WAY_CNT; w++) begin
            if (valid_arr[set_idx][w] && tag_arr[set_idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = way_t'(w);
            end
            if (!valid_arr[set_idx][w] && !has_inv) begin
                has_inv = 1'b1;
                inv_way = way_t'(w);
            end
        end
        if (has_inv)
            victim = inv_way;
        else if (REPL == 2)
            victim = way_t'(lfsr[WAY_W-1:0]) & way_t'(WAY_CNT - 1);
        else
            victim = order_arr[set_idx][0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lfsr        <= 8'h01;
            rd_data     <= '0;
            mem_wr_line <= '0;
            mem_addr    <= '0;
            fill_addr   <= '0;
            fill_line   <= '0;
            victim_q    <= '0;
            for (int unsigned s = 0; s < SET_CNT; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                for (int unsigned i = 0; i < WAY_CNT; i++)
                    order_arr[s][i] <= way_t'(i);
            end
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            case (state)
                IDLE: begin
                    if (req && hit) begin
                        if (wr_req)
                            dirty_arr[set_idx][hit_way] <= 1'b1;
                        else
                            rd_data <= data_arr[set_idx][hit_way][{word_idx, 5'b0} +: 32];
                        if (REPL == 1)
                            order_arr[set_idx] <= promote(order_arr[set_idx], hit_way);
                    end else if (req) begin
                        victim_q  <= victim;
                        fill_addr <= {tag, set_idx};
                        if (valid_arr[set_idx][victim] && dirty_arr[set_idx][victim]) begin
                            mem_addr    <= {tag_arr[set_idx][victim], set_idx};
                            mem_wr_line <= data_arr[set_idx][victim];
                            state       <= SWAP_OUT;
                        end else begin
                            mem_addr <= {tag, set_idx};
                            state    <= SWAP_IN;
                        end
                    end
                end
                SWAP_OUT: begin
                    if (mem_gnt) begin
                        mem_addr <= fill_addr;
                        state    <= SWAP_IN;
                    end
                end
                SWAP_IN: begin
                    if (mem_gnt) begin
                        fill_line <= mem_rd_line;
                        state     <= SWAP_IN_OK;
                    end
                end
                SWAP_IN_OK: begin
                    valid_arr[fill_set][victim_q] <= 1'b1;
                    dirty_arr[fill_set][victim_q] <= 1'b0;
                    if (REPL != 2)
                        order_arr[fill_set] <= promote(order_arr[fill_set], victim_q);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line data and tags need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (state == IDLE && wr_req && hit) begin
            for (int unsigned b = 0; b < 4; b++)
                if (wr_be[b])
                    data_arr[set_idx][hit_way][{word_idx, 2'(b), 3'b0} +: 8] <= wr_data[b*8 +: 8];
        end
        if (state == SWAP_IN_OK) begin
            data_arr[fill_set][victim_q] <= fill_line;
            tag_arr[fill_set][victim_q]  <= fill_tag;
        end
    end

`ifdef ASSOC_CACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == IDLE && req) begin
            if (hit && hit_cnt != '1)
                hit_cnt <= hit_cnt + 32'd1;
            if (!hit && miss_cnt != '1)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache: directed scenarios plus random traffic against a timestamp-based cache model.
module tb_assoc_cache;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sel = 1'b0;
  logic [31:0]  addr = '0;
  logic         rd_req = 1'b0, wr_req = 1'b0;
  logic [31:0]  wr_data = '0;
  logic [3:0]   wr_be = '0;
  logic [255:0] mem_rd_line = '0;
  logic         mem_gnt = 1'b0;

  logic         rd_a, wr_a, gnt_a, rd_f, wr_f, gnt_f;
  logic [31:0]  rd_data_a, rd_data_f, hit_cnt_a, hit_cnt_f, miss_cnt_a, miss_cnt_f;
  logic         miss_a, miss_f, mem_req_a, mem_req_f, mem_we_a, mem_we_f;
  logic [8:0]   mem_addr_a, mem_addr_f;
  logic [255:0] mem_wr_line_a, mem_wr_line_f;

  logic [31:0]  o_rd_data, o_hit_cnt, o_miss_cnt;
  logic         o_miss, o_mem_req, o_mem_we;
  logic [8:0]   o_mem_addr;
  logic [255:0] o_mem_wr_line;

  always #5 clk = ~clk;

  assign rd_a  = rd_req & ~sel;
  assign wr_a  = wr_req & ~sel;
  assign gnt_a = mem_gnt & ~sel;
  assign rd_f  = rd_req & sel;
  assign wr_f  = wr_req & sel;
  assign gnt_f = mem_gnt & sel;

  assign o_rd_data     = sel ? rd_data_f     : rd_data_a;
  assign o_hit_cnt     = sel ? hit_cnt_f     : hit_cnt_a;
  assign o_miss_cnt    = sel ? miss_cnt_f    : miss_cnt_a;
  assign o_miss        = sel ? miss_f        : miss_a;
  assign o_mem_req     = sel ? mem_req_f     : mem_req_a;
  assign o_mem_we      = sel ? mem_we_f      : mem_we_a;
  assign o_mem_addr    = sel ? mem_addr_f    : mem_addr_a;
  assign o_mem_wr_line = sel ? mem_wr_line_f : mem_wr_line_a;

  assoc_cache #(.LINE_ADDR_LEN(3), .SET_ADDR_LEN(3), .TAG_ADDR_LEN(6), .WAY_CNT(4), .REPL(1)) dut (
    .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_a), .wr_req(wr_a), .wr_data(wr_data),
    .wr_be(wr_be), .rd_data(rd_data_a), .miss(miss_a), .mem_req(mem_req_a), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_wr_line(mem_wr_line_a), .mem_rd_line(mem_rd_line),
    .mem_gnt(gnt_a), .hit_cnt(hit_cnt_a), .miss_cnt(miss_cnt_a));

  assoc_cache #(.LINE_ADDR_LEN(3), .SET_ADDR_LEN(3), .TAG_ADDR_LEN(6), .WAY_CNT(4), .REPL(0)) dut_fifo (
    .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_f), .wr_req(wr_f), .wr_data(wr_data),
    .wr_be(wr_be), .rd_data(rd_data_f), .miss(miss_f), .mem_req(mem_req_f), .mem_we(mem_we_f),
    .mem_addr(mem_addr_f), .mem_wr_line(mem_wr_line_f), .mem_rd_line(mem_rd_line),
    .mem_gnt(gnt_f), .hit_cnt(hit_cnt_f), .miss_cnt(miss_cnt_f));

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: per-way stamps; victim is lowest invalid way, else smallest stamp.
  bit           mvalid [8][4];
  bit           mdirty [8][4];
  logic [5:0]   mtag   [8][4];
  logic [255:0] mdata  [8][4];
  int           stamp  [8][4];
  int           now;
  int           mpol;
  logic [255:0] mm [int];
  logic [31:0]  exp_rd;
  int           exp_hits, exp_misses;

  bit           last_hit;
  int           last_cyc;
  logic [8:0]   last_wb_addr, last_fill_addr;
  logic [255:0] last_wb_line;

  task automatic chk(input string name, input bit ok, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [255:0] mem_line(input int la);
    logic [255:0] l;
    if (mm.exists(la)) return mm[la];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'h1000 + 32'(la * 16 + i);
    return l;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 4; w++) begin
        mvalid[s][w] = 1'b0;
        mdirty[s][w] = 1'b0;
        stamp[s][w]  = w;
      end
    now        = 100;
    exp_rd     = '0;
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rd_req = 1'b0;
    wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic access(input bit wr, input bit both, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    int s, w, v, cyc, exp_cyc;
    bit hit, wbv, wb_seen, fill_seen;
    logic [8:0]   wba, fa;
    logic [255:0] wbl;
    s = int'(a[7:5]);
    w = int'(a[4:2]);
    hit = 1'b0;
    v = 0;
    for (int i = 0; i < 4; i++)
      if (mvalid[s][i] && mtag[s][i] == a[13:8]) begin hit = 1'b1; v = i; end
    wbv = 1'b0;
    wba = '0;
    wbl = '0;
    fa  = {a[13:8], a[7:5]};
    if (!hit) begin
      v = -1;
      for (int i = 3; i >= 0; i--) if (!mvalid[s][i]) v = i;
      if (v < 0) begin
        v = 0;
        for (int i = 1; i < 4; i++) if (stamp[s][i] < stamp[s][v]) v = i;
      end
      wbv = mdirty[s][v];
      wba = {mtag[s][v], a[7:5]};
      wbl = mdata[s][v];
    end
    exp_cyc = hit ? 0 : (wbv ? 4 : 3);

    @(negedge clk);
    addr    = a;
    wr_req  = wr | both;
    rd_req  = ~wr | both;
    wr_data = d;
    wr_be   = be;
    cyc = 0;
    wb_seen = 1'b0;
    fill_seen = 1'b0;
    forever begin
      #1;
      if (!o_miss) break;
      cyc++;
      if (o_mem_req) begin
        if (o_mem_we) begin
          chk("wb_expected", wbv === 1'b1, 256'(1'b1), 256'(wbv));
          chk("wb_addr", o_mem_addr === wba, 256'(o_mem_addr), 256'(wba));
          chk("wb_line", o_mem_wr_line === wbl, o_mem_wr_line, wbl);
          mm[int'(wba)] = wbl;
          wb_seen = 1'b1;
          last_wb_addr = o_mem_addr;
          last_wb_line = o_mem_wr_line;
        end else begin
          chk("fill_addr", o_mem_addr === fa, 256'(o_mem_addr), 256'(fa));
          mem_rd_line = mem_line(int'(fa));
          fill_seen = 1'b1;
          last_fill_addr = o_mem_addr;
        end
        mem_gnt = 1'b1;
      end
      if (cyc > 12) break;
      @(negedge clk);
      mem_gnt = 1'b0;
    end
    chk("miss_cycles", cyc === exp_cyc, 256'(cyc), 256'(exp_cyc));
    chk("wb_seen", wb_seen === wbv, 256'(wb_seen), 256'(wbv));
    chk("fill_seen", fill_seen === !hit, 256'(fill_seen), 256'(!hit));

    if (!hit) begin
      mvalid[s][v] = 1'b1;
      mdirty[s][v] = 1'b0;
      mtag[s][v]   = a[13:8];
      mdata[s][v]  = mem_line(int'(fa));
      stamp[s][v]  = now++;
      exp_misses++;
    end
    if (mpol == 1) stamp[s][v] = now++;
    if (wr | both) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mdata[s][v][w*32 + b*8 +: 8] = d[b*8 +: 8];
      mdirty[s][v] = 1'b1;
    end else begin
      exp_rd = mdata[s][v][w*32 +: 32];
    end
    exp_hits++;
    last_hit = hit;
    last_cyc = cyc;

    @(negedge clk);
    mem_gnt = 1'b0;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    chk("rd_data", o_rd_data === exp_rd, 256'(o_rd_data), 256'(exp_rd));
`ifdef ASSOC_CACHE_STATS_EN
    chk("hit_cnt", o_hit_cnt === 32'(exp_hits), 256'(o_hit_cnt), 256'(exp_hits));
    chk("miss_cnt", o_miss_cnt === 32'(exp_misses), 256'(o_miss_cnt), 256'(exp_misses));
`else
    chk("hit_cnt", o_hit_cnt === 32'd0, 256'(o_hit_cnt), 256'(0));
    chk("miss_cnt", o_miss_cnt === 32'd0, 256'(o_miss_cnt), 256'(0));
`endif
  endtask

  initial begin
    model_reset();
    mpol = 1;
    #1;
    chk("reset_rd_data", o_rd_data === 32'd0, 256'(o_rd_data), 256'(0));
    chk("reset_mem_req", o_mem_req === 1'b0, 256'(o_mem_req), 256'(0));
    chk("reset_miss", o_miss === 1'b0, 256'(o_miss), 256'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Cold read, then byte-enable write hit and readback.
    access(0, 0, 32'h0000, 32'h0, 4'h0);
    chk("cold_rd", o_rd_data === 32'h0000_1000, 256'(o_rd_data), 256'(32'h0000_1000));
    chk("cold_penalty", last_cyc === 3, 256'(last_cyc), 256'(3));
    access(1, 0, 32'h0004, 32'hAABBCCDD, 4'b0101);
    chk("wr_hit", last_hit === 1'b1, 256'(last_hit), 256'(1));
    access(0, 0, 32'h0004, 32'h0, 4'h0);
    chk("wr_merge", o_rd_data === 32'h00BB_10DD, 256'(o_rd_data), 256'(32'h00BB_10DD));

    // LRU: tags 0..3 in set 0, touch tag 0, tag 4 must evict tag 1.
    access(0, 0, 32'h0100, 32'h0, 4'h0);
    access(0, 0, 32'h0200, 32'h0, 4'h0);
    access(0, 0, 32'h0300, 32'h0, 4'h0);
    access(0, 0, 32'h0000, 32'h0, 4'h0);
    access(0, 0, 32'h0400, 32'h0, 4'h0);
    chk("lru_fill_addr", last_fill_addr === 9'h020, 256'(last_fill_addr), 256'(9'h020));
    access(0, 0, 32'h0008, 32'h0, 4'h0);
    chk("lru_tag0_hit", last_hit === 1'b1, 256'(last_hit), 256'(1));
    access(0, 0, 32'h0100, 32'h0, 4'h0);
    chk("lru_tag1_evicted", last_hit === 1'b0, 256'(last_hit), 256'(0));

    // FIFO instance: tag 0 re-read does not save it from eviction.
    sel = 1'b1;
    mpol = 0;
    do_reset();
    access(0, 0, 32'h0000, 32'h0, 4'h0);
    access(1, 0, 32'h0004, 32'hAABBCCDD, 4'b0101);
    access(1, 0, 32'h0100, 32'h1111_1111, 4'hF);
    access(1, 0, 32'h0200, 32'h2222_2222, 4'hF);
    access(1, 0, 32'h0300, 32'h3333_3333, 4'hF);
    access(0, 0, 32'h0000, 32'h0, 4'h0);
    chk("fifo_rehit", last_hit === 1'b1, 256'(last_hit), 256'(1));
    access(0, 0, 32'h0400, 32'h0, 4'h0);
    chk("fifo_wb_addr", last_wb_addr === 9'h000, 256'(last_wb_addr), 256'(9'h000));
    chk("fifo_wb_word1", last_wb_line[63:32] === 32'h00BB_10DD, 256'(last_wb_line[63:32]), 256'(32'h00BB_10DD));
    chk("fifo_fill_addr", last_fill_addr === 9'h020, 256'(last_fill_addr), 256'(9'h020));
    chk("fifo_penalty", last_cyc === 4, 256'(last_cyc), 256'(4));

    // Random traffic on the LRU instance; upper and byte-offset address bits are noise.
    sel = 1'b0;
    mpol = 1;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      int unsigned t, s, w, kind;
      logic [31:0] a;
      t = $urandom_range(0, 5);
      s = $urandom_range(0, 1);
      w = $urandom_range(0, 7);
      kind = $urandom_range(0, 9);
      a = ($urandom & 32'hFFFF_C003) | (t << 8) | (s << 5) | (w << 2);
      access(kind < 4, kind == 9, a, $urandom, 4'($urandom_range(0, 15)));
    end

    // Reset while a fill is outstanding drops the request and invalidates everything.
    access(1, 0, 32'h0004, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    addr = 32'h0000_0260;
    rd_req = 1'b1;
    #1;
    chk("mid_idle_miss", o_miss === 1'b1, 256'(o_miss), 256'(1));
    @(negedge clk);
    #1;
    chk("mid_swap_in", {o_mem_req, o_mem_we} === 2'b10, 256'({o_mem_req, o_mem_we}), 256'(2'b10));
    rst = 1'b1;
    rd_req = 1'b0;
    #1;
    chk("mid_rst_mem_req", o_mem_req === 1'b0, 256'(o_mem_req), 256'(0));
    chk("mid_rst_rd_data", o_rd_data === 32'd0, 256'(o_rd_data), 256'(0));
    chk("mid_rst_miss", o_miss === 1'b0, 256'(o_miss), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    access(0, 0, 32'h0004, 32'h0, 4'h0);
    chk("post_rst_invalid", last_hit === 1'b0, 256'(last_hit), 256'(0));
    chk("post_rst_no_wb", last_cyc === 3, 256'(last_cyc), 256'(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/assoc_cache.md
Name: assoc_cache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache for the pipeline's data port.
- Successor to the fixed 4-way cache:
  - per-set replacement state;
  - selectable replacement policy (FIFO/LRU/pseudo-random);
  - byte-enable writes;
  - invalid-way-first victim choice;
  - external line-wide memory handshake instead of an embedded main memory.
- Sits between the MEM stage (which stalls on miss) and the line-based memory model.

Parameters:
- LINE_ADDR_LEN, 3, log2 words per line.
- SET_ADDR_LEN, 3, log2 sets.
- TAG_ADDR_LEN, 6, tag width. Unused upper address bits are ignored.
- WAY_CNT, 4, ways per set. Power of two, 1..16; 1 = direct mapped.
- REPL, 1, replacement policy: 0 = FIFO, 1 = LRU, 2 = pseudo-random (8-bit LFSR).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- addr  in  32  byte address. Fields, LSB up: word[1:0], line, set, tag.
- rd_req  in  1  read request, held until miss=0
- wr_req  in  1  write request, held until miss=0
- wr_data  in  32  write data
- wr_be  in  4  byte enables for the write
- rd_data  out  32  read data, registered
- miss  out  1  stall: request present and not completing this cycle
- mem_req  out  1  memory transaction active
- mem_we  out  1  1 = line write-back, 0 = line fill
- mem_addr  out  TAG+SET  line address {tag,set}
- mem_wr_line  out  32*2^LINE_ADDR_LEN  victim line, word 0 in LSBs
- mem_rd_line  in  32*2^LINE_ADDR_LEN  fill line
- mem_gnt  in  1  one-cycle pulse: transaction complete / mem_rd_line valid
- hit_cnt  out  32  hit counter (optional feature)
- miss_cnt  out  32  miss counter (optional feature)

Behaviour:
- Reset:
  - reset rst, asynchronous, active-high; clock clk;
  - state=IDLE; all valid/dirty=0; rd_data=0; mem_wr_line=0; mem_addr=0;
  - replacement state reset to way order 0..WAY_CNT-1 per set (way 0 is first victim); LFSR=8'h01;
  - mem_req/mem_we deassert immediately because they decode from state.
- Hit: valid & tag match in set, state IDLE.
  - Read hit: rd_data <= word on next edge; miss=0 that cycle.
  - Write hit: merge bytes where wr_be=1; dirty <= 1. rd_data unchanged.
- miss = (rd_req|wr_req) & ~(hit & state==IDLE), combinational.
- rd_req & wr_req together: treated as write.
- Victim selection:
  - lowest-index invalid way if any;
  - else by policy: FIFO = oldest-filled way; LRU = least-recently hit-or-filled way; random = LFSR[WAY_LEN-1:0]. LFSR advances every cycle, polynomial x^8+x^6+x^5+x^4+1.
  - Victim is latched on leaving IDLE and used for the whole miss.
- Replacement-state update, only for the accessed set:
  - LRU: on every hit and every fill.
  - FIFO: on fill only.
- State machine:
  - IDLE, miss with request:
    - dirty valid victim -> SWAP_OUT; latch mem_wr_line and write-back address;
    - otherwise -> SWAP_IN;
    - fill address {tag,set} is latched in both cases.
  - SWAP_OUT: mem_req=1, mem_we=1. On mem_gnt -> SWAP_IN.
  - SWAP_IN: mem_req=1, mem_we=0. On mem_gnt, latch mem_rd_line -> SWAP_IN_OK.
  - SWAP_IN_OK: write line, tag, valid=1, dirty=0 into the latched victim -> IDLE. The held request then hits; minimum miss penalty = 3 cycles.
- Request inputs are ignored outside IDLE. Changing addr mid-miss only means the fill completes for the old address.
- mem_addr, mem_we and mem_wr_line are stable while mem_req=1.
- mem_gnt outside SWAP_OUT/SWAP_IN is ignored.

Optional Feature:
- Macro: ASSOC_CACHE_STATS_EN.
- Defined:
  - hit_cnt increments each IDLE cycle with request and hit;
  - miss_cnt increments once per IDLE->SWAP_OUT/SWAP_IN transition;
  - both saturate at 32'hFFFF_FFFF; both reset to 0.
- Undefined: counters are not instantiated; hit_cnt and miss_cnt are tied to 0.

Test Plan:
- Cold read of 0x0000, memory line words = 0x1000+i:
  - SWAP_IN, then SWAP_IN_OK, then hit; rd_data=0x1000;
  - miss high for exactly 3 cycles with mem_gnt returned the cycle after mem_req rises;
  - miss_cnt=1, hit_cnt=1.
- Write hit: wr 0x0004 with data 0xAABBCCDD, wr_be=4'b0101:
  - subsequent read of 0x0004 returns {orig[31:24],BB,orig[15:8],DD};
  - line is dirty.
- Dirty eviction with REPL=0:
  - write tags 0x00..0x03 in set 0 (addresses 0x0000, 0x0100, 0x0200, 0x0300), then read 0x0400;
  - mem_we=1 with mem_addr={6'h00,3'h0} carrying the written data, then fill of {6'h04,3'h0}.
- LRU with REPL=1:
  - fill ways with tags 0..3, re-read tag 0, access tag 4;
  - tag 1's way is evicted; tag 0 still hits.
- Invalid-first, reset mid-miss:
  - assert rst while in SWAP_IN: mem_req drops the same cycle, rd_data=0, all lines invalid;
  - the next access fills way 0.
- With ASSOC_CACHE_STATS_EN undefined: hit_cnt=miss_cnt=0 throughout.
